// File: rtl/t02_ram_responder.sv
// t02_ram_responder: fixed-latency word-addressed RAM on the team-02 RAM
// request bus. Each request is latched, busy_o is held for LATENCY wait
// cycles, the access is performed, and busy_o drops for exactly one cycle.
//
// Ports:
//   CLK       in   clock, rising edge
//   nRST      in   asynchronous active-low reset
//   Ren       in   read request
//   Wen       in   write request (Ren=Wen is the no-request code)
//   ramaddr   in   byte address, bits [1:0] ignored
//   ramstore  in   write data
//   ramload   out  registered read data
//   busy_o    out  low only in the completion cycle
module t02_ram_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_RELOAD =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;        // 1 = write
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       ramload_q, ramload_d;
  logic              busy_q, busy_d;
  logic [31:0]       mem_q [DEPTH];

  logic              req_rd_c, req_wr_c, req_vld_c, req_oor_c, req_diff_c;
  logic [ADDR_W-1:0] req_idx_c;
  logic              acc_c, acc_wr_c, acc_oor_c;
  logic [ADDR_W-1:0] acc_idx_c;
  logic [31:0]       acc_data_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_idx_c;
  logic [31:0]       mem_wdata_c;
  logic              unused_addr_c;

  // Request decode; both-high and both-low are the no-request code
  assign req_rd_c      = Ren & ~Wen;
  assign req_wr_c      = Wen & ~Ren;
  assign req_vld_c     = req_rd_c | req_wr_c;
  assign req_idx_c     = ramaddr[ADDR_W+1:2];
  assign req_oor_c     = |ramaddr[31:ADDR_W+2];
  assign unused_addr_c = ^ramaddr[1:0];

  // A change of op, word, range or (for writes) data restarts the wait
  assign req_diff_c = (req_wr_c != op_q) | (req_idx_c != idx_q) |
                      (req_oor_c != oor_q) |
                      (req_wr_c & (ramstore != data_q));

  // Next-state, latches and access selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    data_d      = data_q;
    ramload_d   = ramload_q;
    acc_c       = 1'b0;
    acc_wr_c    = op_q;
    acc_idx_c   = idx_q;
    acc_oor_c   = oor_q;
    acc_data_c  = data_q;
    mem_we_c    = 1'b0;
    mem_idx_c   = '0;
    mem_wdata_c = '0;

    case (state_q)
      S_IDLE: begin
        if (req_vld_c) begin
          op_d   = req_wr_c;
          idx_d  = req_idx_c;
          oor_d  = req_oor_c;
          data_d = ramstore;
          if (LATENCY == 0) begin
            // Zero wait: access straight from the bus
            state_d    = S_DONE;
            acc_c      = 1'b1;
            acc_wr_c   = req_wr_c;
            acc_idx_c  = req_idx_c;
            acc_oor_c  = req_oor_c;
            acc_data_c = ramstore;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_RELOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req_vld_c) begin
          state_d = S_IDLE;
        end else if (req_diff_c) begin
          op_d   = req_wr_c;
          idx_d  = req_idx_c;
          oor_d  = req_oor_c;
          data_d = ramstore;
          cnt_d  = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          acc_c   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Perform the access on the edge entering DONE
    if (acc_c) begin
      if (acc_wr_c) begin
        mem_we_c    = ~acc_oor_c;
        mem_idx_c   = acc_idx_c;
        mem_wdata_c = acc_data_c;
      end else begin
        ramload_d = acc_oor_c ? 32'h0 : mem_q[acc_idx_c];
      end
    end

    busy_d = (state_d != S_DONE);
  end

  // Control and request latches
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      data_q    <= '0;
      ramload_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      oor_q     <= oor_d;
      data_q    <= data_d;
      ramload_q <= ramload_d;
      busy_q    <= busy_d;
    end
  end

  // Storage array, cleared by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[mem_idx_c] <= mem_wdata_c;
    end
  end

  assign ramload = ramload_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_t02_ram_responder.sv
// Testbench for t02_ram_responder: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (pending request plus completion deadline).
module tb_t02_ram_responder;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        busy_o;

  t02_ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .Ren      (Ren),
    .Wen      (Wen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .busy_o   (busy_o)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: one pending request with the cycle it must complete in
  bit                m_pend, m_done, p_wr, p_oor;
  logic [ADDR_W-1:0] p_idx;
  logic [31:0]       p_data, m_load;
  logic [31:0]       m_mem [DEPTH];
  int                m_cyc, m_due;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 1'b0;
    m_done = 1'b0;
    p_wr   = 1'b0;
    p_oor  = 1'b0;
    p_idx  = '0;
    p_data = '0;
    m_load = '0;
    m_cyc  = 0;
    m_due  = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
  endfunction

  function automatic void model_step();
    bit                vld, wr, oor;
    logic [ADDR_W-1:0] idx;
    int                cur, nxt;
    vld = Ren ^ Wen;
    wr  = Wen & ~Ren;
    idx = ramaddr[ADDR_W+1:2];
    oor = (ramaddr >> (ADDR_W + 2)) != 32'h0;
    cur = m_cyc;
    nxt = cur + 1;
    m_cyc = nxt;
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_pend) begin
      if (vld) begin
        m_pend = 1'b1;
        p_wr = wr; p_idx = idx; p_oor = oor; p_data = ramstore;
        m_due = cur + int'(LATENCY) + 1;
      end
    end else if (!vld) begin
      m_pend = 1'b0;
    end else if (wr != p_wr || idx != p_idx || oor != p_oor || (wr && ramstore != p_data)) begin
      p_wr = wr; p_idx = idx; p_oor = oor; p_data = ramstore;
      m_due = cur + int'(LATENCY) + 1;
    end
    if (m_pend && m_due == nxt) begin
      m_pend = 1'b0;
      m_done = 1'b1;
      if (!p_wr) m_load = p_oor ? 32'h0 : m_mem[p_idx];
      else if (!p_oor) m_mem[p_idx] = p_data;
    end
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy", 32'(busy_o), 32'(!m_done));
      check("ramload", ramload, m_load);
    end
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
    @(negedge CLK);
  endtask

  // Hold a request until completion (bounded), then one idle cycle
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int n);
    n = 0;
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
    do begin
      @(negedge CLK);
      n++;
    end while (busy_o && n < 40);
    check("access_timeout", 32'(busy_o), 32'd0);
    Ren = 1'b1; Wen = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int n;
    logic r, w;
    logic [31:0] a, d;
    Ren = 1'b1; Wen = 1'b1; ramaddr = '0; ramstore = '0; nRST = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_load", ramload, 32'h0);
    #2 nRST = 1'b1;
    @(negedge CLK);

    // Read word 0 after reset: busy low exactly in cycle c+3
    check("t1_c0_busy", 32'(busy_o), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check("t1_c1_busy", 32'(busy_o), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check("t1_c2_busy", 32'(busy_o), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check("t1_c3_busy", 32'(busy_o), 32'd0);
    check("t1_c3_load", ramload, 32'h0);
    step(1'b1, 1'b1, 32'h0, 32'h0);
    check("t1_c4_busy", 32'(busy_o), 32'd1);

    // Write then misaligned read of the same word
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, n);
    check("t2_wr_cycles", 32'(n), 32'd3);
    do_access(1'b1, 1'b0, 32'h13, 32'h0, n);
    check("t2_rd_load", ramload, 32'hDEADBEEF);

    // Idle code held: never busy-low
    Ren = 1'b1; Wen = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check("t3_idle_busy", 32'(busy_o), 32'd1);
    end
    do_access(1'b1, 1'b0, 32'h10, 32'h0, n);
    check("t3_mem_kept", ramload, 32'hDEADBEEF);

    // Address switch mid-wait restarts the latency
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, n);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    check("t4_delayed_busy", 32'(busy_o), 32'd1);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    check("t4_done_busy", 32'(busy_o), 32'd0);
    check("t4_done_load", ramload, 32'h12345678);
    step(1'b1, 1'b1, 32'h0, 32'h0);

    // Withdrawn write leaves memory and ramload untouched
    step(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("t5_abort_busy", 32'(busy_o), 32'd1);
    check("t5_abort_load", ramload, 32'h12345678);
    step(1'b1, 1'b1, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, n);
    check("t5_rd_aborted", ramload, 32'h0);

    // Out-of-range write completes normally and changes nothing
    do_access(1'b0, 1'b1, 32'h00001000, 32'hA5A5A5A5, n);
    check("t5_oor_cycles", 32'(n), 32'd3);
    do_access(1'b1, 1'b0, 32'h20, 32'h0, n);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, n);
    check("t5_word0_kept", ramload, 32'h0);
    do_access(1'b1, 1'b0, 32'h20, 32'h0, n);
    do_access(1'b1, 1'b0, 32'h00001010, 32'h0, n);
    check("t5_oor_rd", ramload, 32'h0);

    // Reset during a write's wait discards it
    do_access(1'b1, 1'b0, 32'h20, 32'h0, n);
    step(1'b0, 1'b1, 32'h80, 32'h11111111);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy_o), 32'd1);
    check("t6_rst_load", ramload, 32'h0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    Ren = 1'b1; Wen = 1'b1;
    @(negedge CLK);
    do_access(1'b0, 1'b1, 32'h84, 32'h00000055, n);
    do_access(1'b1, 1'b0, 32'h84, 32'h0, n);
    check("t6_rd_84", ramload, 32'h00000055);
    do_access(1'b1, 1'b0, 32'h80, 32'h0, n);
    check("t6_rd_80", ramload, 32'h0);

    // Randomized traffic with sticky requests and rare resets
    r = 1'b1; w = 1'b1; a = '0; d = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int kind;
        kind = int'($urandom_range(0, 9));
        if (kind <= 5) begin r = 1'b1; w = 1'b0; end
        else if (kind <= 8) begin r = 1'b0; w = 1'b1; end
        else begin r = 1'($urandom_range(0, 1)); w = r; end
        if ($urandom_range(0, 15) == 0) a = $urandom | 32'h00000400;
        else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) d = $urandom;
      end
      Ren = r; Wen = w; ramaddr = a; ramstore = d;
      if ($urandom_range(0, 599) == 0) begin
        #2 nRST = 1'b0;
        @(negedge CLK);
        #2 nRST = 1'b1;
      end
      @(negedge CLK);
    end

    Ren = 1'b1; Wen = 1'b1;
    repeat (4) @(negedge CLK);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
